// File: rtl/pad_out_shaper_if.sv
// Core-to-pad shaper bundle: level/enable requests in, pad drive and status out.
// master = core side (drives requests), slave = shaper.
interface pad_out_shaper_if;
    logic d_in;
    logic oe_req;
    logic pad_o;
    logic pad_oe;
    logic busy;
    logic pend;

    modport master (output d_in, oe_req, input pad_o, pad_oe, busy, pend);
    modport slave  (input d_in, oe_req, output pad_o, pad_oe, busy, pend);
endinterface

// File: rtl/pad_out_shaper.sv
// Pad output conditioner: min-dwell level holding and dead-cycle OE turnaround; PAD_OUT_SHAPER_STRETCH_EN turns the filter into a pulse stretcher.
// Latency: d_in->pad_o 1 cycle once dwell is met; oe_req rise->pad_oe TURN+1 cycles.
// No backpressure: requests are sampled every cycle, pend/busy only report deferral.
module pad_out_shaper #(
    parameter int MIN_DWELL = 4,
    parameter int TURN      = 2,
    parameter int CW        = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    pad_out_shaper_if.slave  io
);
    typedef enum logic [1:0] {HIZ, TURN_ON, DRIVE, TURN_OFF} state_t;

    localparam logic [CW-1:0] DWELL_MAX = CW'(MIN_DWELL);
    localparam logic [CW-1:0] TURN_LAST = CW'(TURN);
    localparam logic [CW-1:0] ONE       = CW'(1);

    state_t        state;
    logic [CW-1:0] dwell_cnt;
    logic [CW-1:0] turn_cnt;
    logic          pad_o_q;
    logic          pad_oe_q;
    logic          busy_q;
    logic          dwell_ok;
    logic          diff;

    assign dwell_ok = (dwell_cnt >= DWELL_MAX);
    assign diff     = (io.d_in != pad_o_q);

`ifdef PAD_OUT_SHAPER_STRETCH_EN
    logic toggle_pend;
    assign io.pend = (state == DRIVE) && (toggle_pend || diff);
`else
    assign io.pend = (state == DRIVE) && diff;
`endif

    assign io.pad_o  = pad_o_q;
    assign io.pad_oe = pad_oe_q;
    assign io.busy   = busy_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= HIZ;
            pad_o_q   <= 1'b0;
            pad_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
            dwell_cnt <= DWELL_MAX;
            turn_cnt  <= '0;
`ifdef PAD_OUT_SHAPER_STRETCH_EN
            toggle_pend <= 1'b0;
`endif
        end else begin
            case (state)
                HIZ: begin
                    if (io.oe_req) begin
                        state    <= TURN_ON;
                        turn_cnt <= ONE;
                        busy_q   <= 1'b1;
                    end
                end
                TURN_ON: begin
                    if (!io.oe_req) begin
                        state    <= HIZ;
                        turn_cnt <= '0;
                        busy_q   <= 1'b0;
                    end else if (turn_cnt == TURN_LAST) begin
                        state     <= DRIVE;
                        pad_o_q   <= io.d_in;
                        pad_oe_q  <= 1'b1;
                        busy_q    <= 1'b0;
                        dwell_cnt <= ONE;
                        turn_cnt  <= '0;
                    end else begin
                        turn_cnt <= turn_cnt + ONE;
                    end
                end
                DRIVE: begin
                    // Dropping the enable wins over any pending data change.
                    if (!io.oe_req) begin
                        state    <= TURN_OFF;
                        pad_oe_q <= 1'b0;
                        busy_q   <= 1'b1;
                        turn_cnt <= ONE;
`ifdef PAD_OUT_SHAPER_STRETCH_EN
                        toggle_pend <= 1'b0;
`endif
                    end else begin
`ifdef PAD_OUT_SHAPER_STRETCH_EN
                        // A remembered excursion toggles the pad even if d_in already reverted.
                        if (dwell_ok && toggle_pend) begin
                            pad_o_q     <= ~pad_o_q;
                            dwell_cnt   <= ONE;
                            toggle_pend <= 1'b0;
                        end else if (dwell_ok && diff) begin
                            pad_o_q   <= io.d_in;
                            dwell_cnt <= ONE;
                        end else if (!dwell_ok) begin
                            dwell_cnt <= dwell_cnt + ONE;
                            if (diff) begin
                                toggle_pend <= 1'b1;
                            end
                        end
`else
                        if (dwell_ok && diff) begin
                            pad_o_q   <= io.d_in;
                            dwell_cnt <= ONE;
                        end else if (!dwell_ok) begin
                            dwell_cnt <= dwell_cnt + ONE;
                        end
`endif
                    end
                end
                TURN_OFF: begin
                    // oe_req is deliberately ignored here; re-enable must go through HIZ.
                    if (turn_cnt == TURN_LAST) begin
                        state    <= HIZ;
                        busy_q   <= 1'b0;
                        turn_cnt <= '0;
                    end else begin
                        turn_cnt <= turn_cnt + ONE;
                    end
                end
                default: begin
                    state    <= HIZ;
                    pad_oe_q <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pad_out_shaper.sv
// Bench for pad_out_shaper: directed vector table, async reset sequences, random run against a timestamp model.
module tb_pad_out_shaper;
    localparam int MIN_DWELL = 4;
    localparam int TURN      = 2;
    localparam int NROWS     = 35;

    logic clk;
    logic reset_n;
    int   total;
    int   passed;

    pad_out_shaper_if bus();

    pad_out_shaper #(.MIN_DWELL(MIN_DWELL), .TURN(TURN), .CW(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .io      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       d;
        logic       oe;
        logic [3:0] exp;  // {pad_o, pad_oe, busy, pend}
    } vec_t;

    vec_t tbl [NROWS];

    // Reference model: remembers the edge at which each phase started or pad_o last
    // changed, and decides transitions from elapsed edge counts.
    localparam int M_HIZ = 0, M_ON = 1, M_DRV = 2, M_OFF = 3;
    int   m_mode;
    int   m_edge;
    int   m_t_start;
    int   m_t_chg;
    logic m_po;
    logic m_flag;

    function automatic logic [3:0] m_out(input logic d);
        return {m_po, (m_mode == M_DRV), (m_mode == M_ON || m_mode == M_OFF),
                (m_mode == M_DRV) && ((d != m_po) || m_flag)};
    endfunction

    task automatic m_reset();
        m_mode = M_HIZ;
        m_po   = 1'b0;
        m_flag = 1'b0;
    endtask

    task automatic m_step(input logic d, input logic oe);
        bit ok;
        m_edge++;
        case (m_mode)
            M_HIZ: if (oe) begin m_mode = M_ON; m_t_start = m_edge; end
            M_ON: begin
                if (!oe) m_mode = M_HIZ;
                else if (m_edge - m_t_start == TURN) begin
                    m_mode = M_DRV; m_po = d; m_t_chg = m_edge;
                end
            end
            M_DRV: begin
                ok = (m_edge - m_t_chg) >= MIN_DWELL;
                if (!oe) begin
                    m_mode = M_OFF; m_t_start = m_edge; m_flag = 1'b0;
                end else begin
`ifdef PAD_OUT_SHAPER_STRETCH_EN
                    if (ok && m_flag) begin
                        m_po = ~m_po; m_t_chg = m_edge; m_flag = 1'b0;
                    end else if (ok && d != m_po) begin
                        m_po = d; m_t_chg = m_edge;
                    end else if (!ok && d != m_po) begin
                        m_flag = 1'b1;
                    end
`else
                    if (ok && d != m_po) begin
                        m_po = d; m_t_chg = m_edge;
                    end
`endif
                end
            end
            default: if (m_edge - m_t_start == TURN) m_mode = M_HIZ;
        endcase
    endtask

    function automatic logic [3:0] dut_out();
        return {bus.pad_o, bus.pad_oe, bus.busy, bus.pend};
    endfunction

    task automatic check(input string name, input int idx, input logic [3:0] got, input logic [3:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s[%0d]: pad_o/pad_oe/busy/pend got %b want %b", name, idx, got, exp);
    endtask

    initial begin
        logic d;
        logic oe;
        total  = 0;
        passed = 0;
        m_edge = 0;
        m_t_start = 0;
        m_t_chg = 0;

        // Rows are per cycle: inputs applied in that cycle, outputs seen in that cycle.
        tbl[0]  = '{1'b1, 1'b1, 4'b0000};
        tbl[1]  = '{1'b1, 1'b1, 4'b0010};
        tbl[2]  = '{1'b1, 1'b1, 4'b0010};
        tbl[3]  = '{1'b1, 1'b1, 4'b1100};
        tbl[4]  = '{1'b1, 1'b1, 4'b1100};
        tbl[5]  = '{1'b1, 1'b1, 4'b1100};
        tbl[6]  = '{1'b1, 1'b1, 4'b1100};
        tbl[7]  = '{1'b0, 1'b1, 4'b1101};
        tbl[8]  = '{1'b0, 1'b1, 4'b0100};
        tbl[9]  = '{1'b1, 1'b1, 4'b0101};
        tbl[10] = '{1'b1, 1'b1, 4'b0101};
        tbl[11] = '{1'b1, 1'b1, 4'b0101};
        tbl[12] = '{1'b1, 1'b1, 4'b1100};
        tbl[13] = '{1'b0, 1'b1, 4'b1101};
`ifdef PAD_OUT_SHAPER_STRETCH_EN
        tbl[14] = '{1'b1, 1'b1, 4'b1101};
        tbl[15] = '{1'b1, 1'b1, 4'b1101};
        tbl[16] = '{1'b1, 1'b1, 4'b0101};
        tbl[17] = '{1'b1, 1'b1, 4'b0101};
        tbl[18] = '{1'b1, 1'b1, 4'b0101};
        tbl[19] = '{1'b1, 1'b1, 4'b0101};
`else
        for (int i = 14; i < 20; i++) tbl[i] = '{1'b1, 1'b1, 4'b1100};
`endif
        tbl[20] = '{1'b1, 1'b1, 4'b1100};
        tbl[21] = '{1'b0, 1'b0, 4'b1101};
        tbl[22] = '{1'b0, 1'b1, 4'b1010};
        tbl[23] = '{1'b0, 1'b1, 4'b1010};
        tbl[24] = '{1'b0, 1'b1, 4'b1000};
        tbl[25] = '{1'b0, 1'b1, 4'b1010};
        tbl[26] = '{1'b0, 1'b1, 4'b1010};
        tbl[27] = '{1'b0, 1'b1, 4'b0100};
        tbl[28] = '{1'b0, 1'b0, 4'b0100};
        tbl[29] = '{1'b0, 1'b0, 4'b0010};
        tbl[30] = '{1'b0, 1'b0, 4'b0010};
        tbl[31] = '{1'b0, 1'b1, 4'b0000};
        tbl[32] = '{1'b0, 1'b0, 4'b0010};
        tbl[33] = '{1'b0, 1'b0, 4'b0000};
        tbl[34] = '{1'b0, 1'b0, 4'b0000};

        // Reset state
        reset_n    = 1'b0;
        bus.d_in   = 1'b0;
        bus.oe_req = 1'b0;
        repeat (2) @(negedge clk);
        #1 check("reset", 0, dut_out(), 4'b0000);

        // Directed table: turn-on, dwell, filtering, turn-off, abort
        for (int i = 0; i < NROWS; i++) begin
            @(negedge clk);
            reset_n    = 1'b1;
            bus.d_in   = tbl[i].d;
            bus.oe_req = tbl[i].oe;
            #1 check("vec", i, dut_out(), tbl[i].exp);
        end

        // Async reset mid-TURN_ON, then mid-DRIVE, then resume
        @(negedge clk);
        bus.d_in = 1'b1; bus.oe_req = 1'b1;
        repeat (2) @(negedge clk);
        #1 check("turn_on_busy", 0, dut_out(), 4'b0010);
        #2 reset_n = 1'b0;
        #1 check("rst_turn_on", 0, dut_out(), 4'b0000);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        #1 check("drive_before_rst", 0, dut_out(), 4'b1100);
        #2 reset_n = 1'b0;
        #1 check("rst_drive", 0, dut_out(), 4'b0000);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        #1 check("resume_busy", 0, dut_out(), 4'b0010);
        @(negedge clk);
        #1 check("resume_drive", 0, dut_out(), 4'b1100);

        // Randomized run against the model, with occasional async resets
        @(negedge clk);
        reset_n = 1'b0;
        bus.d_in = 1'b0; bus.oe_req = 1'b0;
        m_reset();
        d = 1'b0; oe = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 19) == 0) oe = ~oe;
            if ($urandom_range(0, 3) == 0) d = ~d;
            bus.d_in = d; bus.oe_req = oe;
            #1 check("rnd", c, dut_out(), m_out(d));
            m_step(d, oe);
            if ($urandom_range(0, 399) == 0) begin
                #2 reset_n = 1'b0;
                m_reset();
                #1 check("rnd_rst", c, dut_out(), m_out(d));
                @(negedge clk);
                reset_n = 1'b1;
            end else begin
                @(negedge clk);
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
